mem_bus_responder: RTL and testbench

//  Responder end of the tagged memory bus driven by icache_controller-style initiators. Accepts BUS_LOAD/BUS_STORE

---
 rtl/sys_defs.sv | 26 ++
 rtl/mem_tag_allocator.sv | 63 ++++++
 rtl/mem_bus_responder.sv | 137 +++++++++++++
 tb/tb_mem_bus_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// sys_defs
//   Shared definitions for the tagged memory bus: command encodings,
//   boolean constants, tag geometry and the simulation delay macro.
//   No ports; imported by mem_tag_allocator and mem_bus_responder.

`define SD

package sys_defs;

   // Command encodings; the unused value 3 is treated like BUS_NONE by the responder.
   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_command_e;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Tag 0 means "no tag", so 4 bits give tags 1..15.
   localparam int NUM_TAGS = 15;
   localparam int TAG_W    = 4;

   typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/mem_tag_allocator.sv
// mem_tag_allocator
//   Tracks which transaction tags (1..NUM_TAGS) are outstanding and offers
//   the lowest-numbered free tag for the next accepted load.
// Ports
//   clock      in   posedge clock
//   reset      in   asynchronous, active-low; clears every busy bit
//   alloc_en   in   mark grant_tag busy at this edge
//   free_en    in   mark free_tag idle at this edge
//   free_tag   in   tag being retired
//   grant_tag  out  lowest free tag, 0 when all tags are busy
//   any_free   out  at least one tag is free
//   busy_vec   out  busy bit per tag, indexed by tag number

module mem_tag_allocator
   import sys_defs::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              alloc_en,
   input  logic              free_en,
   input  tag_t              free_tag,
   output tag_t              grant_tag,
   output logic              any_free,
   output logic [NUM_TAGS:1] busy_vec
);

   logic [NUM_TAGS:1] busy_q;
   logic [NUM_TAGS:1] busy_d;

   // Scanning from the top down lets the lowest free tag overwrite any higher one.
   always_comb begin
      grant_tag = '0;
      for (int t = NUM_TAGS; t >= 1; t--) begin
         if (!busy_q[t]) begin
            grant_tag = tag_t'(t);
         end
      end
   end

   assign any_free = ~&busy_q;
   assign busy_vec = busy_q;

   // A tag is still busy during its own return cycle, so the freed tag can
   // never be the one granted at the same edge.
   always_comb begin
      busy_d = busy_q;
      if (free_en && (free_tag != '0)) begin
         busy_d[free_tag] = FALSE;
      end
      if (alloc_en && any_free) begin
         busy_d[grant_tag] = TRUE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Responder end of the tagged memory bus. Accepts loads and stores, hands
//   back a transaction tag combinationally, and returns load data with that
//   tag LATENCY cycles after the response cycle. Backed by a word-addressed
//   64-bit store that is not cleared by reset.
// Ports
//   clock              in   posedge clock
//   reset              in   asynchronous, active-low
//   proc2mem_command   in   BUS_NONE / BUS_LOAD / BUS_STORE (3 acts as NONE)
//   proc2mem_addr      in   byte address, bits [2:0] ignored
//   proc2mem_data      in   store data
//   mem2proc_response  out  combinational accepted tag, 0 = rejected/none
//   mem2proc_tag       out  registered returning tag, 0 = idle
//   mem2proc_data      out  registered load data, 0 when mem2proc_tag is 0

module mem_bus_responder
   import sys_defs::*;
#(
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned MEM_WORDS = 8192
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output tag_t        mem2proc_response,
   output tag_t        mem2proc_tag,
   output logic [63:0] mem2proc_data
);

   localparam int AW   = $clog2(MEM_WORDS);
   localparam int LAST = int'(LATENCY) - 1;

   logic [63:0]       mem_array [MEM_WORDS];

   logic [AW-1:0]     word_idx;
   logic              in_range;
   logic              is_load;
   logic              is_store;
   logic              accept;
   logic              load_accept;
   logic              store_accept;
   tag_t              grant_tag;
   logic              any_free;
   logic [NUM_TAGS:1] busy_vec;
   logic              unused_addr_lsbs;

   // A nonzero tag in a stage doubles as that stage's valid bit.
   tag_t              pipe_tag_q  [LATENCY];
   tag_t              pipe_tag_d  [LATENCY];
   logic [63:0]       pipe_data_q [LATENCY];
   logic [63:0]       pipe_data_d [LATENCY];

   assign unused_addr_lsbs = ^proc2mem_addr[2:0];

   // Any address bit above the word index makes the request out of range.
   assign word_idx = proc2mem_addr[3 +: AW];
   assign in_range = (proc2mem_addr[63:3+AW] == '0);

   // Gating with reset keeps the response at 0 for the whole time reset is held.
   always_comb begin
      is_load           = (proc2mem_command == BUS_LOAD);
      is_store          = (proc2mem_command == BUS_STORE);
      accept            = reset && any_free && in_range && (is_load || is_store);
      load_accept       = accept && is_load;
      store_accept      = accept && is_store;
      mem2proc_response = accept ? grant_tag : '0;
   end

   // Stores take a tag for the response but never occupy it.
   mem_tag_allocator u_tag_alloc (
      .clock     (clock),
      .reset     (reset),
      .alloc_en  (load_accept),
      .free_en   (mem2proc_tag != '0),
      .free_tag  (mem2proc_tag),
      .grant_tag (grant_tag),
      .any_free  (any_free),
      .busy_vec  (busy_vec)
   );

   // Backing store has no reset so preloaded contents survive a bus reset.
   always_ff @(posedge clock) begin
      if (store_accept) begin
         mem_array[word_idx] <= proc2mem_data;
      end
   end

   // The load reads the array combinationally, so a store at the same edge
   // cannot affect it; the last stage is the output register.
   always_comb begin
      pipe_tag_d[0]  = load_accept ? grant_tag : '0;
      pipe_data_d[0] = load_accept ? mem_array[word_idx] : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
         pipe_tag_d[i]  = pipe_tag_q[i-1];
         pipe_data_d[i] = pipe_data_q[i-1];
      end
   end

   // Reset drops in-flight loads immediately rather than letting them drain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            pipe_tag_q[i]  <= '0;
            pipe_data_q[i] <= '0;
         end
      end else begin
         pipe_tag_q  <= pipe_tag_d;
         pipe_data_q <= pipe_data_d;
      end
   end

   assign mem2proc_tag  = pipe_tag_q[LAST];
   assign mem2proc_data = pipe_data_q[LAST];

   // Protocol self-check: a returning tag must be busy, and no tag may be in
   // flight twice.
   logic dup_tag;
   logic ret_not_busy;

   always_comb begin
      dup_tag = FALSE;
      for (int i = 0; i < int'(LATENCY); i++) begin
         for (int j = i + 1; j < int'(LATENCY); j++) begin
            if ((pipe_tag_q[i] != '0) && (pipe_tag_q[i] == pipe_tag_q[j])) begin
               dup_tag = TRUE;
            end
         end
      end
      ret_not_busy = (mem2proc_tag != '0) && !busy_vec[mem2proc_tag];
   end

   a_tag_protocol : assert property (@(posedge clock) disable iff (!reset)
      !dup_tag && !ret_not_busy);

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder
//   Directed bench for mem_bus_responder: one LATENCY=4 instance for the
//   main traffic and a LATENCY=20 instance for tag exhaustion.

module tb_mem_bus_responder;
   import sys_defs::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic [1:0]  cmd   = 2'd0;
   logic [63:0] addr  = '0;
   logic [63:0] wdata = '0;
   logic [3:0]  resp;
   logic [3:0]  rtag;
   logic [63:0] rdata;

   logic [1:0]  cmd20   = 2'd0;
   logic [63:0] addr20  = '0;
   logic [63:0] wdata20 = '0;
   logic [3:0]  resp20;
   logic [3:0]  rtag20;
   logic [63:0] rdata20;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_LOAD  = 2'd1;
   localparam logic [1:0] C_STORE = 2'd2;

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   mem_bus_responder #(.LATENCY(4), .MEM_WORDS(8192)) u_dut (
      .clock             (clock),
      .reset             (reset),
      .proc2mem_command  (cmd),
      .proc2mem_addr     (addr),
      .proc2mem_data     (wdata),
      .mem2proc_response (resp),
      .mem2proc_tag      (rtag),
      .mem2proc_data     (rdata)
   );

   mem_bus_responder #(.LATENCY(20), .MEM_WORDS(64)) u_dut20 (
      .clock             (clock),
      .reset             (reset),
      .proc2mem_command  (cmd20),
      .proc2mem_addr     (addr20),
      .proc2mem_data     (wdata20),
      .mem2proc_response (resp20),
      .mem2proc_tag      (rtag20),
      .mem2proc_data     (rdata20)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one bus cycle on the LATENCY=4 instance starting just after a
   // posedge, checks all outputs on the falling edge, then moves to the next cycle.
   task automatic applyStimulus(input logic [1:0] c, input logic [63:0] a,
                                input logic [63:0] d, input logic [3:0] exp_resp,
                                input logic [3:0] exp_tag, input logic [63:0] exp_data,
                                input string name);
      cmd   = c;
      addr  = a;
      wdata = d;
      @(negedge clock);
      checkOutput({name, ".resp"}, 64'(resp), 64'(exp_resp));
      checkOutput({name, ".tag"},  64'(rtag), 64'(exp_tag));
      checkOutput({name, ".data"}, rdata, exp_data);
      @(posedge clock);
      #1;
   endtask

   // Watchdog so a wedged run still reports.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, with a LOAD presented to show the response is gated.
      cmd  = C_LOAD;
      addr = 64'h0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst.resp", 64'(resp), 64'd0);
      checkOutput("rst.tag",  64'(rtag), 64'd0);
      checkOutput("rst.data", rdata, 64'd0);
      cmd   = C_NONE;
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Basic load with fixed latency.
      applyStimulus(C_STORE, 64'h100, 64'hCAFE, 4'd1, 4'd0, 64'd0, "t1.st");
      applyStimulus(C_LOAD,  64'h100, 64'd0,    4'd1, 4'd0, 64'd0, "t1.ld");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t1.wait");
      end
      applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'hCAFE, "t1.ret");
      applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0,    "t1.after");

      // Back-to-back loads: tags cycle 1..5 and return in issue order.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(C_STORE, 64'(i * 8), 64'h1000 + 64'(i), 4'd1, 4'd0, 64'd0, "t2.pre");
      end
      for (int t = 0; t < 24; t++) begin
         logic [3:0]  er;
         logic [3:0]  et;
         logic [63:0] ed;
         er = (t < 20) ? 4'((t % 5) + 1) : 4'd0;
         et = (t >= 4) ? 4'(((t - 4) % 5) + 1) : 4'd0;
         ed = (t >= 4) ? 64'h1000 + 64'(t - 4) : 64'd0;
         applyStimulus((t < 20) ? C_LOAD : C_NONE, 64'(t * 8), 64'd0, er, et, ed, "t2.stream");
      end

      // Store/load ordering on the same word.
      applyStimulus(C_STORE, 64'h40, 64'h1234, 4'd1, 4'd0, 64'd0, "t4.st");
      applyStimulus(C_LOAD,  64'h40, 64'd0,    4'd1, 4'd0, 64'd0, "t4.ld");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t4.noret");
      end
      applyStimulus(C_NONE,  64'd0,  64'd0,    4'd0, 4'd1, 64'h1234, "t4.new");
      applyStimulus(C_LOAD,  64'h40, 64'd0,    4'd1, 4'd0, 64'd0,    "t4.ld2");
      applyStimulus(C_STORE, 64'h40, 64'h5678, 4'd2, 4'd0, 64'd0,    "t4.st2");
      applyStimulus(C_NONE,  64'd0,  64'd0,    4'd0, 4'd0, 64'd0,    "t4.w");
      applyStimulus(C_NONE,  64'd0,  64'd0,    4'd0, 4'd0, 64'd0,    "t4.w");
      applyStimulus(C_NONE,  64'd0,  64'd0,    4'd0, 4'd1, 64'h1234, "t4.old");
      applyStimulus(C_LOAD,  64'h40, 64'd0,    4'd1, 4'd0, 64'd0,    "t4.ld3");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t4.w");
      end
      applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'h5678, "t4.upd");

      // Rejects: out-of-range addresses and the reserved command.
      applyStimulus(C_LOAD,  64'h10000,              64'd0,    4'd0, 4'd0, 64'd0, "t5.oor");
      applyStimulus(C_LOAD,  64'h8000_0000_0000_0100, 64'd0,   4'd0, 4'd0, 64'd0, "t5.hi");
      applyStimulus(2'd3,    64'h100,                64'd0,    4'd0, 4'd0, 64'd0, "t5.cmd3");
      applyStimulus(C_STORE, 64'h10000,              64'hDEAD, 4'd0, 4'd0, 64'd0, "t5.st_oor");
      applyStimulus(C_LOAD,  64'h0,                  64'd0,    4'd1, 4'd0, 64'd0, "t5.ld0");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t5.quiet");
      end
      applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'h1000, "t5.nowrap");

      // Tag exhaustion on the LATENCY=20 instance.
      for (int t = 0; t < 22; t++) begin
         logic [3:0] er;
         logic [3:0] et;
         er = (t < 15) ? 4'(t + 1) : ((t == 21) ? 4'd1 : 4'd0);
         et = (t == 20) ? 4'd1 : ((t == 21) ? 4'd2 : 4'd0);
         cmd20  = C_LOAD;
         addr20 = 64'h0;
         @(negedge clock);
         checkOutput("t3.resp", 64'(resp20), 64'(er));
         checkOutput("t3.tag",  64'(rtag20), 64'(et));
         @(posedge clock);
         #1;
      end
      cmd20 = C_NONE;

      // Asynchronous reset with loads in flight.
      applyStimulus(C_LOAD, 64'h0,  64'd0, 4'd1, 4'd0, 64'd0, "t6.ld0");
      applyStimulus(C_LOAD, 64'h8,  64'd0, 4'd2, 4'd0, 64'd0, "t6.ld1");
      applyStimulus(C_LOAD, 64'h10, 64'd0, 4'd3, 4'd0, 64'd0, "t6.ld2");
      applyStimulus(C_NONE, 64'd0,  64'd0, 4'd0, 4'd0, 64'd0, "t6.idle");
      checkOutput("t6.pre_tag",  64'(rtag), 64'd1);
      checkOutput("t6.pre_data", rdata, 64'h1000);
      cmd  = C_LOAD;
      addr = 64'h0;
      #1;
      reset = 1'b0;
      #1;
      checkOutput("t6.rst_resp", 64'(resp), 64'd0);
      checkOutput("t6.rst_tag",  64'(rtag), 64'd0);
      checkOutput("t6.rst_data", rdata, 64'd0);
      @(posedge clock);
      #1;
      checkOutput("t6.hold_tag", 64'(rtag), 64'd0);
      cmd = C_NONE;
      #2;
      reset = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t6.stale");
      end
      applyStimulus(C_LOAD, 64'h0, 64'd0, 4'd1, 4'd0, 64'd0, "t6.ld_new");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0, "t6.w");
      end
      applyStimulus(C_NONE, 64'd0, 64'd0, 4'd0, 4'd1, 64'h1000, "t6.ret");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
